chngy_update_ctrl: RTL and testbench
====================================

Name: chngy_update_ctrl

Overview:
- Sequencer that applies one branch-admittance change record to the stored Y matrix by driving the change-in-Y add/sub datapath.
- Accepts change records over a valid/ready stream and does read-modify-write on the Y-matrix memory.
- For each step it issues operands and add/sub mode to the datapath, waits for its done flag, and writes the result back.
- Sits between the change-file reader and the Y-matrix RAM / updateY datapath pair.

Parameters:
- IDX_W, 4, node index width; matrix is 2^IDX_W x 2^IDX_W.
- TIMEOUT, 16, max cycles in EXEC waiting for dp_done before abort.
- CNT_W, 16, width of upd_count.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- chg_valid  in  1  change record valid
- chg_ready  out  1  controller can accept a record
- chg_row  in  IDX_W  node i
- chg_col  in  IDX_W  node j
- chg_dy  in  48  delta admittance, [47:24] real, [23:0] imag, two's complement
- y_addr  out  2*IDX_W  Y RAM address = {row,col}
- y_rd_en  out  1  RAM read strobe; 1-cycle read latency
- y_rdata  in  48  RAM read data
- y_wr_en  out  1  RAM write strobe
- y_wdata  out  48  RAM write data
- dp_exec_en  out  1  datapath execute enable
- dp_in1  out  48  operand 1 (current Y entry)
- dp_in2  out  48  operand 2 (captured chg_dy)
- dp_sub  out  1  1 = in1-in2, 0 = in1+in2
- dp_result  in  48  datapath result
- dp_done  in  1  datapath result valid
- busy  out  1  record in progress
- rec_done  out  1  1-cycle pulse when record finished
- upd_count  out  CNT_W  total RAM writes since reset, wraps
- timeout_err  out  1  sticky: a step timed out

Behaviour:
- Reset (sync, active-high): state=IDLE. All strobes, dp_exec_en, busy, rec_done, timeout_err = 0. upd_count = 0. y_addr, y_wdata, dp_in1/2 = 0. dp_sub = 1. Reset mid-record aborts with no further RAM write.
- chg_ready = 1 only in IDLE. Handshake when chg_valid & chg_ready; row, col, dy captured into registers. Inputs are ignored at all other times.
- Step list for off-diagonal record (row != col), executed in this order:
  - S0: Y[r][c] -= dy
  - S1: Y[c][r] -= dy
  - S2: Y[r][r] += dy
  - S3: Y[c][c] += dy
- Diagonal record (row == col): S2 only.
- FSM: IDLE -> RD -> RDW -> EXEC -> WR -> (next step ? RD : FIN) -> IDLE.
  - RD: y_addr = step address, y_rd_en = 1 for one cycle.
  - RDW: y_rdata is valid this cycle and is registered into dp_in1; dp_in2 = dy; dp_sub set per step.
  - EXEC: dp_exec_en = 1 throughout; operands held stable. On the cycle dp_done = 1, register dp_result into y_wdata and go to WR.
    - If TIMEOUT cycles elapse without dp_done: set timeout_err, skip WR for that step, go to the next step.
  - WR: y_wr_en = 1 for one cycle at the same y_addr; upd_count += 1.
  - FIN: rec_done = 1 for one cycle, busy = 0 next cycle.
- dp_exec_en = 0 in every state other than EXEC, so the datapath clears between steps.
- busy = 1 from the cycle after the handshake through FIN inclusive.
- Step latency = 3 + L cycles, where dp_done arrives on the L-th EXEC cycle (L >= 1).
- No arithmetic in this block beyond counters; upd_count wraps from 2^CNT_W-1 to 0.
- dp_done while not in EXEC is ignored.

Optional Feature:
- Macro CHNGY_ZERO_SKIP_EN.
- Defined: a record with chg_dy == 0 is accepted, makes no RAM access and no datapath activity, and rec_done pulses the cycle after the handshake. upd_count is unchanged.
- Undefined: zero-delta records run the full step sequence normally.

Test Plan:
- Off-diagonal record: row=1, col=2, dy=0x000010_000020, RAM pre-loaded with 0x000100_000100 everywhere, dp modelled as a 2-cycle add/sub. Required: writes to addresses 0x12 and 0x21 = 0x0000F0_0000E0, writes to 0x11 and 0x22 = 0x000110_000120. upd_count = 4, exactly one rec_done, total 4*(3+2)+1 cycles.
- Diagonal record: row=col=3. Required: a single write to 0x33 with dp_sub = 0, upd_count = 1, chg_ready low until after FIN.
- Timeout: dp_done held low. Required: after 16 EXEC cycles timeout_err = 1, no y_wr_en for that step, remaining steps still complete, rec_done pulses.
- Back-to-back: chg_valid held high with two records. Required: the second record is accepted only on the cycle after FIN, and no RAM write overlaps between records.
- Reset mid-EXEC: assert reset while in EXEC of S1. Required: all outputs at reset values next cycle, no write for S1, upd_count = 0.
- With CHNGY_ZERO_SKIP_EN defined: dy = 0. Required: y_rd_en and y_wr_en never assert, rec_done pulses 1 cycle after the handshake.

Source files
------------

// File: rtl/chngy_update_ctrl.sv
// Change-in-Y update sequencer: applies one branch-admittance change record to the
// Y-matrix RAM through the add/sub datapath. Optional zero-delta skip: CHNGY_ZERO_SKIP_EN.
module chngy_update_ctrl #(
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 chg_valid,
  output logic                 chg_ready,
  input  logic [IDX_W-1:0]     chg_row,
  input  logic [IDX_W-1:0]     chg_col,
  input  logic [47:0]          chg_dy,
  output logic [2*IDX_W-1:0]   y_addr,
  output logic                 y_rd_en,
  input  logic [47:0]          y_rdata,
  output logic                 y_wr_en,
  output logic [47:0]          y_wdata,
  output logic                 dp_exec_en,
  output logic [47:0]          dp_in1,
  output logic [47:0]          dp_in2,
  output logic                 dp_sub,
  input  logic [47:0]          dp_result,
  input  logic                 dp_done,
  output logic                 busy,
  output logic                 rec_done,
  output logic [CNT_W-1:0]     upd_count,
  output logic                 timeout_err,
  output logic [2:0]           dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WR   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_row;
  logic [IDX_W-1:0]     r_col;
  logic [47:0]          r_dy;
  logic [1:0]           r_step;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic [2*IDX_W-1:0]   r_addr;
  logic                 r_rd_en;
  logic                 r_wr_en;
  logic [47:0]          r_wdata;
  logic                 r_exec_en;
  logic [47:0]          r_in1;
  logic [47:0]          r_in2;
  logic                 r_sub;
  logic                 r_busy;
  logic                 r_rec_done;
  logic [CNT_W-1:0]     r_upd_count;
  logic                 r_tmo_err;

  logic                 w_last_step;
  logic [1:0]           w_next_step;
  logic [1:0]           w_first_step;
  logic                 w_zero_skip;

  // Steps 0/1 subtract at the off-diagonal pair, steps 2/3 add at the two diagonals.
  function automatic logic [2*IDX_W-1:0] step_addr(input logic [1:0] s,
                                                   input logic [IDX_W-1:0] r,
                                                   input logic [IDX_W-1:0] c);
    case (s)
      2'd0:    return {r, c};
      2'd1:    return {c, r};
      2'd2:    return {r, r};
      default: return {c, c};
    endcase
  endfunction

  assign w_last_step  = (r_row == r_col) || (r_step == 2'd3);
  assign w_next_step  = r_step + 2'd1;
  assign w_first_step = (chg_row == chg_col) ? 2'd2 : 2'd0;

`ifdef CHNGY_ZERO_SKIP_EN
  assign w_zero_skip = (chg_dy == 48'd0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // Handshake: a record transfers on any cycle where chg_valid && chg_ready; chg_ready
  // is high only in IDLE and record inputs are ignored whenever it is low.
  assign chg_ready = (r_state == ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_dy        <= '0;
      r_step      <= '0;
      r_tmo_cnt   <= '0;
      r_addr      <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wdata     <= '0;
      r_exec_en   <= 1'b0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_sub       <= 1'b1;
      r_busy      <= 1'b0;
      r_rec_done  <= 1'b0;
      r_upd_count <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rec_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (chg_valid) begin
            r_row  <= chg_row;
            r_col  <= chg_col;
            r_dy   <= chg_dy;
            r_busy <= 1'b1;
            if (w_zero_skip) begin
              r_rec_done <= 1'b1;
              r_state    <= ST_FIN;
            end else begin
              r_step  <= w_first_step;
              r_addr  <= step_addr(w_first_step, chg_row, chg_col);
              r_rd_en <= 1'b1;
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: r_state <= ST_RDW;
        ST_RDW: begin
          r_in1     <= y_rdata;
          r_in2     <= r_dy;
          r_sub     <= ~r_step[1];
          r_exec_en <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dp_done) begin
            r_wdata   <= dp_result;
            r_exec_en <= 1'b0;
            r_wr_en   <= 1'b1;
            r_state   <= ST_WR;
          end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // Abandon this step without a write and move on.
            r_tmo_err <= 1'b1;
            r_exec_en <= 1'b0;
            if (w_last_step) begin
              r_rec_done <= 1'b1;
              r_state    <= ST_FIN;
            end else begin
              r_step  <= w_next_step;
              r_addr  <= step_addr(w_next_step, r_row, r_col);
              r_rd_en <= 1'b1;
              r_state <= ST_RD;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_WR: begin
          r_upd_count <= r_upd_count + 1'b1;
          if (w_last_step) begin
            r_rec_done <= 1'b1;
            r_state    <= ST_FIN;
          end else begin
            r_step  <= w_next_step;
            r_addr  <= step_addr(w_next_step, r_row, r_col);
            r_rd_en <= 1'b1;
            r_state <= ST_RD;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign y_addr      = r_addr;
  assign y_rd_en     = r_rd_en;
  assign y_wr_en     = r_wr_en;
  assign y_wdata     = r_wdata;
  assign dp_exec_en  = r_exec_en;
  assign dp_in1      = r_in1;
  assign dp_in2      = r_in2;
  assign dp_sub      = r_sub;
  assign busy        = r_busy;
  assign rec_done    = r_rec_done;
  assign upd_count   = r_upd_count;
  assign timeout_err = r_tmo_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_chngy_update_ctrl.sv
// Directed bench for chngy_update_ctrl: RAM preloaded with 0x000100_000100, 2-cycle
// add/sub datapath model, per-scenario tasks with inline checks.
module tb_chngy_update_ctrl;

  localparam logic [47:0] PRELOAD = 48'h000100_000100;
  localparam logic [47:0] DY      = 48'h000010_000020;
  localparam logic [47:0] RES_SUB = 48'h0000F0_0000E0;
  localparam logic [47:0] RES_ADD = 48'h000110_000120;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        chg_valid = 1'b0;
  logic        chg_ready;
  logic [3:0]  chg_row = '0;
  logic [3:0]  chg_col = '0;
  logic [47:0] chg_dy = '0;
  logic [7:0]  y_addr;
  logic        y_rd_en;
  logic [47:0] y_rdata = '0;
  logic        y_wr_en;
  logic [47:0] y_wdata;
  logic        dp_exec_en;
  logic [47:0] dp_in1;
  logic [47:0] dp_in2;
  logic        dp_sub;
  logic [47:0] dp_result;
  logic        dp_done;
  logic        busy;
  logic        rec_done;
  logic [15:0] upd_count;
  logic        timeout_err;
  logic [2:0]  dbg_state;

  logic        dp_hold = 1'b0;
  logic [4:0]  dp_cnt = '0;
  int          rec_cnt = 0;
  int          rd_cnt = 0;
  int          exec_cnt = 0;
  logic [56:0] obs_q[$];
  logic [56:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  chngy_update_ctrl #(.IDX_W(4), .TIMEOUT(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .chg_valid(chg_valid), .chg_ready(chg_ready),
    .chg_row(chg_row), .chg_col(chg_col), .chg_dy(chg_dy),
    .y_addr(y_addr), .y_rd_en(y_rd_en), .y_rdata(y_rdata),
    .y_wr_en(y_wr_en), .y_wdata(y_wdata),
    .dp_exec_en(dp_exec_en), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_sub(dp_sub),
    .dp_result(dp_result), .dp_done(dp_done),
    .busy(busy), .rec_done(rec_done), .upd_count(upd_count),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / environment models ----------------
  always #5 clock = ~clock;

  // RAM returns the preload one cycle after a read strobe and junk otherwise.
  always @(posedge clock) begin
    y_rdata <= y_rd_en ? PRELOAD : 48'hBAD0BAD0BAD0;
    dp_cnt  <= dp_exec_en ? dp_cnt + 5'd1 : 5'd0;
  end

  assign dp_done = dp_exec_en && !dp_hold && (dp_cnt == 5'd1);

  always_comb begin
    dp_result = 48'hDEADBEEF0BAD;
    if (dp_done) begin
      if (dp_sub) dp_result = {dp_in1[47:24] - dp_in2[47:24], dp_in1[23:0] - dp_in2[23:0]};
      else        dp_result = {dp_in1[47:24] + dp_in2[47:24], dp_in1[23:0] + dp_in2[23:0]};
    end
  end

  // Monitor: every RAM write is logged as {dp_sub, addr, data}.
  always @(posedge clock) begin
    if (y_wr_en)    obs_q.push_back({dp_sub, y_addr, y_wdata});
    if (rec_done)   rec_cnt <= rec_cnt + 1;
    if (y_rd_en)    rd_cnt <= rd_cnt + 1;
    if (dp_exec_en) exec_cnt <= exec_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    chg_valid = 1'b0;
    dp_hold = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_rec(input logic [3:0] row, input logic [3:0] col, input logic [47:0] dy);
    chg_row = row;
    chg_col = col;
    chg_dy = dy;
    chg_valid = 1'b1;
    tick();
    chg_valid = 1'b0;
  endtask

  task automatic wait_rec(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (rec_done) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (chg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", chg_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rec_done !== 1'b0) begin failures++; $display("FAIL reset_rec_done: got %b expected 0", rec_done); end
    checks++; if ({y_rd_en, y_wr_en, dp_exec_en} !== 3'b000) begin failures++;
      $display("FAIL reset_strobes: got %b expected 000", {y_rd_en, y_wr_en, dp_exec_en}); end
    checks++; if (dp_sub !== 1'b1) begin failures++; $display("FAIL reset_dp_sub: got %b expected 1", dp_sub); end
    checks++; if (upd_count !== 16'd0) begin failures++; $display("FAIL reset_upd_count: got %0d expected 0", upd_count); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++; if ({y_addr, y_wdata, dp_in1, dp_in2} !== 152'd0) begin failures++;
      $display("FAIL reset_data: got %0h expected 0", {y_addr, y_wdata, dp_in1, dp_in2}); end
  endtask

  task automatic test_offdiag();
    int n;
    int ob;
    int rb;
    do_reset();
    ob = obs_q.size();
    rb = rec_cnt;
    send_rec(4'd1, 4'd2, DY);
    wait_rec(60, n);
    checks++; if (n != 20) begin failures++; $display("FAIL offdiag_latency: got %0d expected 20", n); end
    tick();
    checks++; if (rec_cnt - rb != 1) begin failures++; $display("FAIL offdiag_rec_pulses: got %0d expected 1", rec_cnt - rb); end
    checks++; if (upd_count !== 16'd4) begin failures++; $display("FAIL offdiag_upd_count: got %0d expected 4", upd_count); end
    checks++; if ({busy, chg_ready} !== 2'b01) begin failures++; $display("FAIL offdiag_idle: got %b expected 01", {busy, chg_ready}); end
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h12, RES_SUB});
    exp_q.push_back({1'b1, 8'h21, RES_SUB});
    exp_q.push_back({1'b0, 8'h11, RES_ADD});
    exp_q.push_back({1'b0, 8'h22, RES_ADD});
    checks++;
    if (obs_q.size() - ob != exp_q.size()) begin
      failures++; $display("FAIL offdiag_write_count: got %0d expected %0d", obs_q.size() - ob, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[ob+i] !== exp_q[i]) begin failures++;
          $display("FAIL offdiag_write%0d: got %0h expected %0h", i, obs_q[ob+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_diag();
    int n;
    int ob;
    bit ready_seen;
    do_reset();
    ob = obs_q.size();
    send_rec(4'd3, 4'd3, DY);
    n = -1;
    ready_seen = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (chg_ready) ready_seen = 1'b1;
      tick();
      if (rec_done) begin
        n = i;
        if (chg_ready) ready_seen = 1'b1;
        break;
      end
    end
    checks++; if (n != 5) begin failures++; $display("FAIL diag_latency: got %0d expected 5", n); end
    checks++; if (ready_seen) begin failures++; $display("FAIL diag_ready_early: got 1 expected 0"); end
    tick();
    checks++; if (chg_ready !== 1'b1) begin failures++; $display("FAIL diag_ready_after: got %b expected 1", chg_ready); end
    checks++; if (upd_count !== 16'd1) begin failures++; $display("FAIL diag_upd_count: got %0d expected 1", upd_count); end
    checks++;
    if (obs_q.size() - ob != 1) begin
      failures++; $display("FAIL diag_write_count: got %0d expected 1", obs_q.size() - ob);
    end else begin
      checks++;
      if (obs_q[ob] !== {1'b0, 8'h33, RES_ADD}) begin failures++;
        $display("FAIL diag_write: got %0h expected %0h", obs_q[ob], {1'b0, 8'h33, RES_ADD}); end
    end
  endtask

  task automatic test_timeout();
    int n;
    int t_err;
    int ob;
    int rb;
    do_reset();
    ob = obs_q.size();
    rb = rec_cnt;
    dp_hold = 1'b1;
    send_rec(4'd1, 4'd2, DY);
    n = -1;
    t_err = -1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (timeout_err && t_err < 0) begin
        t_err = i;
        dp_hold = 1'b0;
      end
      if (rec_done) begin
        n = i;
        break;
      end
    end
    dp_hold = 1'b0;
    checks++; if (t_err != 18) begin failures++; $display("FAIL timeout_when: got %0d expected 18", t_err); end
    checks++; if (n != 33) begin failures++; $display("FAIL timeout_latency: got %0d expected 33", n); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    checks++; if (upd_count !== 16'd3) begin failures++; $display("FAIL timeout_upd_count: got %0d expected 3", upd_count); end
    checks++; if (rec_cnt - rb != 1) begin failures++; $display("FAIL timeout_rec_pulses: got %0d expected 1", rec_cnt - rb); end
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h21, RES_SUB});
    exp_q.push_back({1'b0, 8'h11, RES_ADD});
    exp_q.push_back({1'b0, 8'h22, RES_ADD});
    checks++;
    if (obs_q.size() - ob != exp_q.size()) begin
      failures++; $display("FAIL timeout_write_count: got %0d expected %0d", obs_q.size() - ob, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[ob+i] !== exp_q[i]) begin failures++;
          $display("FAIL timeout_write%0d: got %0h expected %0h", i, obs_q[ob+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int ob;
    int rd_a;
    int hs_b;
    int w_at_fin;
    bit prev_ready;
    do_reset();
    ob = obs_q.size();
    chg_row = 4'd4; chg_col = 4'd4; chg_dy = 48'h000001_000002;
    chg_valid = 1'b1;
    tick();
    chg_row = 4'd5; chg_col = 4'd5; chg_dy = 48'h000003_000004;
    rd_a = -1;
    hs_b = -1;
    w_at_fin = -1;
    for (int i = 1; i <= 30; i++) begin
      prev_ready = chg_ready;
      tick();
      if (prev_ready) begin
        hs_b = i;
        break;
      end
      if (rec_done && rd_a < 0) begin
        rd_a = i;
        w_at_fin = obs_q.size() - ob;
      end
    end
    chg_valid = 1'b0;
    checks++; if (rd_a != 5) begin failures++; $display("FAIL b2b_first_done: got %0d expected 5", rd_a); end
    checks++; if (hs_b != 7) begin failures++; $display("FAIL b2b_second_accept: got %0d expected 7", hs_b); end
    checks++; if (w_at_fin != 1) begin failures++; $display("FAIL b2b_writes_at_fin: got %0d expected 1", w_at_fin); end
    wait_rec(30, n);
    checks++; if (n != 5) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 5", n); end
    tick();
    checks++; if (upd_count !== 16'd2) begin failures++; $display("FAIL b2b_upd_count: got %0d expected 2", upd_count); end
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h44, 48'h000101_000102});
    exp_q.push_back({1'b0, 8'h55, 48'h000103_000104});
    checks++;
    if (obs_q.size() - ob != exp_q.size()) begin
      failures++; $display("FAIL b2b_write_count: got %0d expected %0d", obs_q.size() - ob, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[ob+i] !== exp_q[i]) begin failures++;
          $display("FAIL b2b_write%0d: got %0h expected %0h", i, obs_q[ob+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    int ob;
    int rb;
    do_reset();
    ob = obs_q.size();
    rb = rec_cnt;
    send_rec(4'd1, 4'd2, DY);
    for (int i = 0; i < 7; i++) tick();
    checks++; if ({dp_exec_en, y_addr} !== {1'b1, 8'h21}) begin failures++;
      $display("FAIL midrst_in_s1_exec: got %0h expected %0h", {dp_exec_en, y_addr}, {1'b1, 8'h21}); end
    reset = 1'b1;
    tick();
    checks++; if ({busy, dp_exec_en, y_wr_en, y_rd_en, dp_sub, chg_ready, rec_done, timeout_err} !== 8'b0000_1100) begin
      failures++; $display("FAIL midrst_ctrl: got %b expected 00001100",
        {busy, dp_exec_en, y_wr_en, y_rd_en, dp_sub, chg_ready, rec_done, timeout_err}); end
    checks++; if ({upd_count, y_addr, y_wdata, dp_in1, dp_in2} !== 168'd0) begin failures++;
      $display("FAIL midrst_data: got %0h expected 0", {upd_count, y_addr, y_wdata, dp_in1, dp_in2}); end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (upd_count !== 16'd0) begin failures++; $display("FAIL midrst_upd_count: got %0d expected 0", upd_count); end
    checks++; if (rec_cnt != rb) begin failures++; $display("FAIL midrst_rec_done: got %0d expected 0", rec_cnt - rb); end
    checks++;
    if (obs_q.size() - ob != 1) begin
      failures++; $display("FAIL midrst_write_count: got %0d expected 1", obs_q.size() - ob);
    end else begin
      checks++;
      if (obs_q[ob] !== {1'b1, 8'h12, RES_SUB}) begin failures++;
        $display("FAIL midrst_write: got %0h expected %0h", obs_q[ob], {1'b1, 8'h12, RES_SUB}); end
    end
  endtask

`ifdef CHNGY_ZERO_SKIP_EN
  task automatic test_zero_delta();
    int ob;
    int rdb;
    int exb;
    do_reset();
    ob = obs_q.size();
    rdb = rd_cnt;
    exb = exec_cnt;
    send_rec(4'd2, 4'd3, 48'd0);
    checks++; if ({rec_done, busy} !== 2'b11) begin failures++; $display("FAIL zero_rec_done: got %b expected 11", {rec_done, busy}); end
    tick();
    checks++; if ({rec_done, busy, chg_ready} !== 3'b001) begin failures++;
      $display("FAIL zero_after: got %b expected 001", {rec_done, busy, chg_ready}); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (rd_cnt - rdb != 0) begin failures++; $display("FAIL zero_reads: got %0d expected 0", rd_cnt - rdb); end
    checks++; if (obs_q.size() - ob != 0) begin failures++; $display("FAIL zero_writes: got %0d expected 0", obs_q.size() - ob); end
    checks++; if (exec_cnt - exb != 0) begin failures++; $display("FAIL zero_exec: got %0d expected 0", exec_cnt - exb); end
    checks++; if (upd_count !== 16'd0) begin failures++; $display("FAIL zero_upd_count: got %0d expected 0", upd_count); end
  endtask
`else
  task automatic test_zero_delta();
    int n;
    int ob;
    do_reset();
    ob = obs_q.size();
    send_rec(4'd2, 4'd3, 48'd0);
    wait_rec(60, n);
    checks++; if (n != 20) begin failures++; $display("FAIL zero_latency: got %0d expected 20", n); end
    tick();
    checks++; if (upd_count !== 16'd4) begin failures++; $display("FAIL zero_upd_count: got %0d expected 4", upd_count); end
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h23, PRELOAD});
    exp_q.push_back({1'b1, 8'h32, PRELOAD});
    exp_q.push_back({1'b0, 8'h22, PRELOAD});
    exp_q.push_back({1'b0, 8'h33, PRELOAD});
    checks++;
    if (obs_q.size() - ob != exp_q.size()) begin
      failures++; $display("FAIL zero_write_count: got %0d expected %0d", obs_q.size() - ob, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[ob+i] !== exp_q[i]) begin failures++;
          $display("FAIL zero_write%0d: got %0h expected %0h", i, obs_q[ob+i], exp_q[i]); end
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_offdiag();
    test_diag();
    test_timeout();
    test_back_to_back();
    test_reset_mid_exec();
    test_zero_delta();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
